// File: rtl/mmio_uart_tx_if.sv
// Processor data-memory load/store bus as seen by a memory-mapped responder.
// The master drives address/data/strobes; the responder returns ReadData and Hit combinationally.
interface mmio_uart_tx_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  ReadData, Hit
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output ReadData, Hit
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: zero-latency register loads, stores queue bytes in a small FIFO.
// TxSerial is registered one cycle behind the FSM; a store into a full FIFO is dropped and sets overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0800,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          TxSerial,
  output logic          TxBusy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic          enable;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic       hit;
  logic [1:0] offset;
  logic       wr_en;
  logic       rd_en;
  logic       full;
  logic       empty;
  logic       active;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       ctrl_wr;
  logic       unused_bits;

  assign hit      = bus.Address[31:4] == BASE_ADDR[31:4];
  assign bus.Hit  = hit;
  assign offset   = bus.Address[3:2];
  assign wr_en    = bus.MemWrite && hit;
  assign rd_en    = bus.MemRead && hit;
  assign full     = count == DEPTH_C;
  assign empty    = count == '0;
  assign active   = state != IDLE;
  assign pop      = (state == IDLE) && !empty && enable;
  assign push_req = wr_en && (offset == 2'd0);
  // A pop on the same edge frees the head slot, so a full FIFO can still take the byte.
  assign push     = push_req && (!full || pop);
  assign ctrl_wr  = wr_en && (offset == 2'd2);
  assign TxBusy   = !empty || active;

  assign unused_bits = ^{bus.WriteData[31:8], bus.Address[1:0]};

  always_comb begin
    bus.ReadData = '0;
    if (rd_en) begin
      case (offset)
        2'd1:    bus.ReadData = {23'd0, overflow, 5'(count), active, empty, full};
        2'd2:    bus.ReadData = {31'd0, enable};
        default: bus.ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b1;
    end else begin
      if (push) begin
        mem[tail] <= bus.WriteData[7:0];
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
      end else if (ctrl_wr && bus.WriteData[1]) begin
        overflow <= 1'b0;
      end
      if (ctrl_wr) begin
        enable <= bus.WriteData[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      TxSerial <= 1'b1;
    end else begin
      case (state)
        START:   TxSerial <= 1'b0;
        DATA:    TxSerial <= shreg[bit_idx];
        default: TxSerial <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= mem[head];
            baud  <= BAUD_LAST;
            state <= START;
          end
        end
        START: begin
          if (baud == '0) begin
            baud    <= BAUD_LAST;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud - BW'(1);
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud    <= BAUD_LAST;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud <= baud - BW'(1);
          end
        end
        STOP: begin
          if (baud == '0) begin
            state <= IDLE;
          end else begin
            baud <= baud - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-timeline model checked every cycle, plus hand-computed waveform pins.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h1001_0800;
  localparam int C  = 4;
  localparam int D  = 4;
  localparam int FL = 10 * C;
  localparam int TRACE_LEN = 2048;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_serial;
  logic tx_busy;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus_if();

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .TxSerial(tx_serial),
    .TxBusy(tx_busy)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: FIFO as a queue; a frame is a timeline of edges since its pop.
  logic [7:0] q[$];
  logic       m_en = 1'b1;
  logic       m_ovf = 1'b0;
  int         since = FL;
  logic [7:0] cur = 8'h00;

  logic trace [TRACE_LEN];
  logic busy_tr [TRACE_LEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    int pre;
    bit pop;
    bit hit;
    bit push_req;
    bit ctrl_wr;
    cyc++;
    hit = bus_if.Address[31:4] == BASE[31:4];
    if (reset) begin
      q.delete();
      m_en   = 1'b1;
      m_ovf  = 1'b0;
      since  = FL;
      chk_en = 1'b1;
    end else begin
      pre      = q.size();
      pop      = (since >= FL) && (pre > 0) && m_en;
      push_req = bus_if.MemWrite && hit && (bus_if.Address[3:2] == 2'd0);
      ctrl_wr  = bus_if.MemWrite && hit && (bus_if.Address[3:2] == 2'd2);
      if (pop) cur = q.pop_front();
      if (push_req) begin
        if (pre < D || pop) q.push_back(bus_if.WriteData[7:0]);
        else m_ovf = 1'b1;
      end
      if (ctrl_wr) begin
        m_en = bus_if.WriteData[0];
        if (bus_if.WriteData[1]) m_ovf = 1'b0;
      end
      if (pop) since = 0;
      else if (since < FL) since++;
    end
  end

  always @(negedge clk) begin
    if (cyc < TRACE_LEN) begin
      trace[cyc]   = tx_serial;
      busy_tr[cyc] = tx_busy;
    end
  end

  always @(negedge clk) begin
    logic        exp_tx;
    logic        exp_hit;
    logic [31:0] exp_rd;
    int          k;
    if (chk_en) begin
      k = (since - 1) / C;
      if (since == 0)  exp_tx = 1'b1;
      else if (k == 0) exp_tx = 1'b0;
      else if (k <= 8) exp_tx = cur[k-1];
      else             exp_tx = 1'b1;
      exp_hit = bus_if.Address[31:4] == BASE[31:4];
      exp_rd  = 32'd0;
      if (bus_if.MemRead && exp_hit) begin
        case (bus_if.Address[3:2])
          2'd1: exp_rd = {23'd0, m_ovf, 5'(q.size()), since < FL, q.size() == 0, q.size() == D};
          2'd2: exp_rd = {31'd0, m_en};
          default: exp_rd = 32'd0;
        endcase
      end
      check("model_tx", {31'd0, tx_serial}, {31'd0, exp_tx});
      check("model_busy", {31'd0, tx_busy}, {31'd0, (q.size() > 0) || (since < FL)});
      check("model_hit", {31'd0, bus_if.Hit}, {31'd0, exp_hit});
      check("model_rdata", bus_if.ReadData, exp_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus_if.Address = a;
    bus_if.MemRead = 1'b1;
    #1;
    check(name, bus_if.ReadData, exp);
    step();
    bus_if.MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int edge_n);
    bus_if.Address   = a;
    bus_if.WriteData = d;
    bus_if.MemWrite  = 1'b1;
    step();
    edge_n = cyc;
    bus_if.MemWrite = 1'b0;
  endtask

  initial begin
    int w;
    int x;
    int s1;
    int e0;
    logic a5_bits [8];
    a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    bus_if.Address   = BASE;
    bus_if.WriteData = 32'd0;
    bus_if.MemWrite  = 1'b0;
    bus_if.MemRead   = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    check("reset_tx", {31'd0, tx_serial}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    rd(BASE + 32'h4, 32'h002, "reset_status");
    rd(BASE + 32'h8, 32'h001, "reset_ctrl");
    bus_if.Address = BASE + 32'h100;
    bus_if.MemRead = 1'b1;
    #1;
    check("miss_hit", {31'd0, bus_if.Hit}, 32'd0);
    check("miss_rdata", bus_if.ReadData, 32'd0);
    step();
    bus_if.MemRead = 1'b0;

    // Single 0xA5 frame.
    wr(BASE, 32'hA5, w);
    repeat (50) step();
    check("a5_pop_cycle_high", {31'd0, trace[w+1]}, 32'd1);
    check("a5_start_fall", {31'd0, trace[w+2]}, 32'd0);
    check("a5_start_last", {31'd0, trace[w+5]}, 32'd0);
    for (int i = 0; i < 8; i++) check("a5_data_bit", {31'd0, trace[w+7+4*i]}, {31'd0, a5_bits[i]});
    check("a5_stop", {31'd0, trace[w+38]}, 32'd1);
    check("a5_busy_last", {31'd0, busy_tr[w+40]}, 32'd1);
    check("a5_busy_off", {31'd0, busy_tr[w+41]}, 32'd0);

    // Five consecutive stores, then overflow and its clear.
    wr(BASE, 32'h01, w);
    for (int i = 2; i <= 5; i++) wr(BASE, i, x);
    rd(BASE + 32'h4, 32'h025, "five_status");
    wr(BASE, 32'h06, x);
    rd(BASE + 32'h4, 32'h125, "ovf_status");
    wr(BASE + 32'h8, 32'h3, x);
    rd(BASE + 32'h4, 32'h025, "ovf_cleared");
    repeat (230) step();
    s1 = w + 2;
    check("bb_first_start", {31'd0, trace[s1]}, 32'd0);
    check("bb_last_data", {31'd0, trace[s1+35]}, 32'd0);
    for (int i = 36; i <= 40; i++) check("bb_stop_idle_high", {31'd0, trace[s1+i]}, 32'd1);
    check("bb_next_start", {31'd0, trace[s1+41]}, 32'd0);
    check("bb_f2_bit1", {31'd0, trace[s1+50]}, 32'd1);
    rd(BASE + 32'h4, 32'h002, "drained_status");

    // Enable cleared mid-frame.
    wr(BASE, 32'h3C, w);
    wr(BASE, 32'h81, x);
    repeat (10) step();
    wr(BASE + 32'h8, 32'h0, x);
    rd(BASE + 32'h8, 32'h000, "ctrl_disabled");
    repeat (60) step();
    check("dis_frame_bit6", {31'd0, trace[w+31]}, 32'd0);
    check("dis_frame_stop", {31'd0, trace[w+38]}, 32'd1);
    rd(BASE + 32'h4, 32'h008, "held_status");
    wr(BASE + 32'h8, 32'h1, e0);
    repeat (5) step();
    check("reen_pop_high", {31'd0, trace[e0+1]}, 32'd1);
    check("reen_start", {31'd0, trace[e0+2]}, 32'd0);
    repeat (50) step();

    // Reset in the middle of DATA with bytes still queued.
    wr(BASE, 32'hF0, w);
    wr(BASE, 32'h0F, x);
    wr(BASE, 32'h55, x);
    repeat (15) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_tx", {31'd0, tx_serial}, 32'd1);
    check("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
    rd(BASE + 32'h4, 32'h002, "rst_mid_status");
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that answers the processor's data-memory load/store bus as a responder. It sits beside the data RAM on the same address/data/strobe signals. Stores to its data register queue bytes in a small FIFO, and a serializer drives them out as 8N1 frames. Loads from its status register let software poll for FIFO space and completion.

## Interface
Parameters:
- BASE_ADDR, 32'h1001_0800, byte address of register 0; must be 16-byte aligned.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries; power of two, range 2..16.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Address  in  32  byte address from the processor's EX/MEM stage.
- WriteData  in  32  store data; only bits [7:0] are used.
- MemWrite  in  1  store strobe.
- MemRead  in  1  load strobe.
- ReadData  out  32  load data, combinational.
- Hit  out  1  combinational; high when Address[31:4] == BASE_ADDR[31:4].
- TxSerial  out  1  serial line; idle high.
- TxBusy  out  1  high while the FIFO is non-empty or a frame is in flight.

## Operation
- Register map (offset = Address[3:0]):
  - 0x0 TXDATA: write pushes WriteData[7:0]; read returns 0.
  - 0x4 STATUS, read-only: bit0 full, bit1 empty, bit2 shifter active, bits[7:3] FIFO count, bit8 sticky overflow; other bits 0.
  - 0x8 CTRL: bit0 enable (read/write). Writing bit1 = 1 clears overflow; bit1 reads 0.
  - 0xC: reads 0; writes ignored.
- Access qualification:
  - A write is taken only when MemWrite && Hit.
  - ReadData is nonzero only when MemRead && Hit; otherwise it is 0.
  - Offsets with Address[1:0] != 0 are treated as the aligned word.
- Push: a TXDATA write when not full stores the byte at the tail.
  - A write when full drops the byte and sets overflow.
  - Exception: a pop in the same cycle frees space, so the push is accepted and overflow stays clear.
- Pop: occurs in IDLE when the FIFO is non-empty and enable = 1. The head byte is loaded into the shift register.
- FSM states:
  - IDLE: TxSerial = 1. On pop, go to START.
  - START: TxSerial = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index advances when the baud counter expires; after bit 7, go to STOP.
  - STOP: TxSerial = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: loads CLKS_PER_BIT-1 on entry to each bit and decrements to 0. Its width is clog2(CLKS_PER_BIT).
- Enable:
  - Clearing enable mid-frame does not abort the frame; it only blocks the next pop.
  - Pushes are accepted regardless of enable.
- FIFO pointers wrap modulo FIFO_DEPTH. Count is FIFO_DEPTH when full.
- TxBusy = !empty || state != IDLE.

## Timing
- Reset values:
  - State IDLE, TxSerial = 1, TxBusy = 0.
  - FIFO empty (count 0), overflow 0, enable 1, baud counter 0, bit index 0.
- Reset mid-frame: on the next edge TxSerial = 1 and all queued bytes are discarded.
- Load latency: 0 cycles; ReadData is valid in the same cycle MemRead && Hit is asserted.
- Store latency: a push is visible in STATUS on the cycle after the write edge.
- Transmit latency:
  - A push into an empty FIFO while IDLE and enabled: the pop occurs on the next edge.
  - TxSerial falls on the edge after the pop, i.e. the 2nd edge after the write.
- Frame length: 10*CLKS_PER_BIT cycles, start bit through stop bit.
- Back-to-back frames: exactly 1 IDLE cycle (TxSerial = 1) between the stop bit and the next start bit.
- A CTRL write and a TXDATA write cannot coincide (single bus).

## Test plan
- Reset, then idle: TxSerial = 1; a load of STATUS returns 0x002 (empty); ReadData = 0 for a load of BASE_ADDR+0x100 (Hit = 0).
- Store 0xA5 to TXDATA with CLKS_PER_BIT = 4 -> TxSerial falls 2 edges later, carries bits 1,0,1,0,0,1,0,1 each for 4 cycles, then stop high; TxBusy deasserts after 40 cycles plus pop latency.
- Five stores 0x01..0x05 on consecutive cycles while IDLE, FIFO_DEPTH 4:
  - The first is popped at once, so all five are accepted and overflow = 0.
  - The 6th store during the first frame sets STATUS bit8; a CTRL write of 0x3 clears it.
- Back-to-back frames: measure exactly 1 high cycle between stop and start, and 10*CLKS_PER_BIT cycles per frame.
- Enable cleared mid-frame via a CTRL write of 0x0 -> the current frame completes and the queued bytes remain (count unchanged); re-enable -> the next frame starts 2 edges later.
- Reset asserted during DATA -> TxSerial = 1, STATUS = 0x002, and TxBusy = 0 on the next edge.
